// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding one UART transmitter from NUM_SRC byte streams.
// Define UART_ARB_PKT_LOCK_EN to hold the grant on one source until it offers a byte with src_last set.
module uart_tx_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = 2
) (
    input  logic                          sysclk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]         uart_tx_data,
    output logic                          uart_tx_valid,
    input  logic                          uart_tx_busy,
    output logic [ID_W-1:0]               grant_id,
    output logic                          arb_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state;
    logic [ID_W-1:0] rr_ptr, winner, rr_next;
    logic [NUM_SRC-1:0] eligible;
    logic found, grant;
`ifdef UART_ARB_PKT_LOCK_EN
    logic locked;
    logic [ID_W-1:0] lock_id;
    always_comb eligible = locked ? src_valid & (NUM_SRC'(1) << lock_id) : src_valid;
`else
    logic unused_last;
    assign unused_last = ^src_last;
    assign eligible = src_valid;
`endif
    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        winner = '0;
        found = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            idx = idx >= NUM_SRC ? idx - NUM_SRC : idx;
            if (eligible[idx]) begin
                winner = ID_W'(idx);
                found = 1'b1;
            end
        end
    end
    assign grant     = found && state == IDLE && !uart_tx_busy && !rst;
    assign src_ready = grant ? NUM_SRC'(1) << winner : '0;
    assign rr_next   = winner == ID_W'(NUM_SRC - 1) ? '0 : winner + 1'b1;
    assign arb_busy  = state != IDLE;
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state         <= IDLE;
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= '0;
            grant_id      <= '0;
            rr_ptr        <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
            locked        <= 1'b0;
            lock_id       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (grant) begin
                    uart_tx_data  <= src_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    grant_id      <= winner;
                    rr_ptr        <= rr_next;
                    uart_tx_valid <= 1'b1;
                    state         <= ISSUE;
`ifdef UART_ARB_PKT_LOCK_EN
                    locked        <= !src_last[winner];
                    lock_id       <= winner;
`endif
                end
                ISSUE: if (!uart_tx_busy) begin
                    uart_tx_valid <= 1'b0;
                    state         <= WAIT_BUSY;
                end
                WAIT_BUSY: if (uart_tx_busy) state <= WAIT_DONE;
                default: if (!uart_tx_busy) state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter between several byte-stream requesters. Each source offers bytes on a valid/ready handshake. The arbiter picks one byte at a time and issues it to the transmitter's `tx_data`/`tx_data_valid` port. It then tracks the transmitter's `tx_busy` until the frame completes. It sits between the application logic (status reporters, debug dumpers, command responders) and the UART transmit block.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 8: byte width; must match the transmitter's `DATA_WIDTH`.
- `ID_W`, default 2: grant index width; must satisfy ceil(log2(NUM_SRC)) ≤ `ID_W`, with `ID_W` ≥ 1.

Ports:
- `sysclk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `src_data`  in  NUM_SRC*DATA_WIDTH: source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `src_valid`  in  NUM_SRC: per-source byte offered.
- `src_last`  in  NUM_SRC: per-source last byte of packet; used only with `UART_ARB_PKT_LOCK_EN`.
- `src_ready`  out  NUM_SRC: per-source accept. A byte transfers on a cycle where valid & ready.
- `uart_tx_data`  out  DATA_WIDTH: to transmitter `tx_data`; registered.
- `uart_tx_valid`  out  1: to transmitter `tx_data_valid`; registered.
- `uart_tx_busy`  in  1: from transmitter `tx_busy`.
- `grant_id`  out  ID_W: index of the source whose byte is in flight; registered.
- `arb_busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - Eligible sources are those with `src_valid`=1. In IDLE, `uart_tx_busy` must also be 0.
  - The winner is the first eligible index at or after `rr_ptr`, searching upward with wrap (NUM_SRC-1 → 0).
  - `src_ready` is combinational: one-hot at the winner, only while in IDLE and only when an eligible source exists. All other bits are 0.
- **On acceptance**
  - Register `uart_tx_data` ← winner's byte and `grant_id` ← winner.
  - Set `rr_ptr` ← (winner+1) mod NUM_SRC.
  - Go to ISSUE.
- **ISSUE**
  - `uart_tx_valid`=1.
  - Leave for WAIT_BUSY on the first cycle where `uart_tx_busy`=0; valid drops on that edge.
  - If busy is already 1, hold valid.
- **WAIT_BUSY**: wait for `uart_tx_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE**: wait for `uart_tx_busy`=0, then go to IDLE.
- `uart_tx_data` is held stable from acceptance until the transmitter has latched it.
- Sources not granted are never acknowledged and keep their byte. No byte is dropped or duplicated.

## Timing
- Reset values:
  - state IDLE, `uart_tx_valid`=0, `uart_tx_data`=0, `grant_id`=0, `arb_busy`=0.
  - `src_ready`=0 during reset; `rr_ptr`=0; lock cleared.
- Latency:
  - Acceptance edge at cycle T → `uart_tx_valid`=1 during cycle T+1 → transmitter busy from T+2.
  - WAIT_BUSY normally lasts 1 cycle.
- Back-to-back throughput: one byte per transmitter frame plus 3 cycles (acceptance, ISSUE, WAIT_BUSY).
- The arbiter never asserts `src_ready` while `uart_tx_busy`=1.
  - The transmitter has no reset, so after `rst` mid-frame the arbiter waits in IDLE for busy to fall before granting.
  - A frame in progress is never corrupted by reset.
- Simultaneous requests: exactly one ready per grant cycle.
  - A source requesting continuously waits at most NUM_SRC-1 bytes.
- `rst` asserted in any state overrides all transitions on that edge.

## Configuration
- `UART_ARB_PKT_LOCK_EN` defined: packet lock.
  - Accepting a byte with `src_last`=0 locks arbitration to that source.
  - While locked, only the locked source is eligible, regardless of `rr_ptr`. Others wait even if valid.
  - Accepting a byte with `src_last`=1 releases the lock.
  - `rr_ptr` updates normally on each acceptance.
- Not defined: `src_last` is ignored and every byte is arbitrated independently (byte interleaving allowed).

## Test plan
Use the real transmitter with `SCALE`=4 (frame = 40 cycles).
- Single byte: src1 valid with 0xA5 → `src_ready`[1] pulses once; `uart_tx_valid` is 1 for exactly one cycle one cycle later with data 0xA5. Serial line shows 0, 1,0,1,0,0,1,0,1, 1 (LSB first); `arb_busy` falls after the stop bit.
- Round-robin: all four sources hold valid with 0x10,0x11,0x12,0x13 from reset → transmit order 0x10,0x11,0x12,0x13. Then src0 and src2 remain valid → order alternates src0, src2.
- Back-pressure: src3 valid during src0's frame → src3 ready only after `uart_tx_busy` falls; its byte is unchanged and sent exactly once.
- Reset mid-frame: assert `rst` at bit 4 of a frame for one cycle, with src2 valid → no `src_ready` until `uart_tx_busy`=0. Then the src2 byte is sent and `grant_id`=2.
- Packet lock (macro defined): src0 sends 3 bytes with last on the third while src1 is valid → serial order src0,src0,src0,src1.
- Packet lock (macro undefined): same stimulus → order src0,src1,src0,src0.
